// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Branch resolution stage behind the 16-bit comparator; strobes
//               the compare, decides taken/not-taken, loads PC and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_kind,
    input  logic [WIDTH-1:0] br_pc,
    input  logic [WIDTH-1:0] br_offset,
    output logic             cmp_eq,
    output logic             cmp_nq,
    input  logic [WIDTH-1:0] cmp_r,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_target,
    output logic             flush,
    output logic [15:0]      taken_count
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CMP_WAIT = 2'd1;
    localparam logic [1:0] S_RESOLVE  = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    localparam logic [1:0] K_NOP  = 2'b00;
    localparam logic [1:0] K_BEQ  = 2'b01;
    localparam logic [1:0] K_BNE  = 2'b10;
    localparam logic [1:0] K_JUMP = 2'b11;

    localparam bit             HAS_FLUSH  = (FLUSH_CYCLES > 0);
    localparam int             FCW        = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);
    localparam logic [FCW-1:0] FCNT_ONE   = FCW'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       kind_q, kind_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] off_q, off_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic [15:0]      count_q, count_d;

    logic             w_accept;
    logic             w_capture;
    logic             w_taken;
    logic             w_unused_cmp_hi;

    // The comparator result is a full word, but only its LSB carries the verdict.
    assign w_unused_cmp_hi = ^cmp_r[WIDTH-1:1];

    assign w_accept  = br_valid & br_ready;
    assign w_capture = w_accept & (br_kind != K_NOP);
    assign w_taken   = (state_q == S_RESOLVE) & ((kind_q == K_JUMP) | cmp_r[0]);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_capture) begin
                    state_d = (br_kind == K_JUMP) ? S_RESOLVE : S_CMP_WAIT;
                end
            end
            S_CMP_WAIT: begin
                state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                state_d = (w_taken && HAS_FLUSH) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (fcnt_q <= FCNT_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        br_ready    = (state_q == S_IDLE) & ~rst;
        cmp_eq      = (state_q == S_CMP_WAIT) & (kind_q == K_BEQ);
        cmp_nq      = (state_q == S_CMP_WAIT) & (kind_q == K_BNE);
        pc_load     = w_taken;
        pc_target   = w_taken ? (pc_q + off_q) : '0;
        flush       = (state_q == S_FLUSH);
        taken_count = count_q;
    end

    // ------------------------------------------------------------------
    // Captured request, flush down-counter and taken counter
    // ------------------------------------------------------------------
    always_comb begin
        kind_d  = kind_q;
        pc_d    = pc_q;
        off_d   = off_q;
        fcnt_d  = fcnt_q;
        count_d = count_q;

        // A nop is consumed without disturbing the previously captured request.
        if (w_capture) begin
            kind_d = br_kind;
            pc_d   = br_pc;
            off_d  = br_offset;
        end

        if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
            fcnt_d = FLUSH_LOAD;
        end else if ((state_q == S_FLUSH) && (fcnt_q != '0)) begin
            fcnt_d = fcnt_q - FCNT_ONE;
        end

        if (w_taken && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q  <= K_NOP;
            pc_q    <= '0;
            off_q   <= '0;
            fcnt_q  <= '0;
            count_q <= '0;
        end else begin
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            off_q   <= off_d;
            fcnt_q  <= fcnt_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Scoreboard bench for branch_resolve (FLUSH_CYCLES=2 and =0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_kind;
    logic [15:0] br_pc;
    logic [15:0] br_offset;
    logic        cmp_eq;
    logic        cmp_nq;
    logic [15:0] cmp_r;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        flush;
    logic [15:0] taken_count;

    logic        v0;
    logic        rdy0;
    logic [1:0]  k0;
    logic [15:0] pc0;
    logic [15:0] off0;
    logic        eq0;
    logic        nq0;
    logic        ld0;
    logic [15:0] tg0;
    logic        fl0;
    logic [15:0] cnt0;

    logic [15:0] r_next;
    logic [15:0] exp_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] obs;
    logic [63:0] obs0;

    always #5 clk = ~clk;

    branch_resolve #(.WIDTH(16), .FLUSH_CYCLES(FC)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_kind    (br_kind),
        .br_pc      (br_pc),
        .br_offset  (br_offset),
        .cmp_eq     (cmp_eq),
        .cmp_nq     (cmp_nq),
        .cmp_r      (cmp_r),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .flush      (flush),
        .taken_count(taken_count)
    );

    branch_resolve #(.WIDTH(16), .FLUSH_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .br_valid   (v0),
        .br_ready   (rdy0),
        .br_kind    (k0),
        .br_pc      (pc0),
        .br_offset  (off0),
        .cmp_eq     (eq0),
        .cmp_nq     (nq0),
        .cmp_r      (16'h0000),
        .pc_load    (ld0),
        .pc_target  (tg0),
        .flush      (fl0),
        .taken_count(cnt0)
    );

    // Registered comparator: latches the wanted verdict only when strobed,
    // otherwise presents the opposite LSB so early sampling is exposed.
    always @(posedge clk or posedge rst) begin
        if (rst) cmp_r <= 16'h0000;
        else     cmp_r <= (cmp_eq || cmp_nq) ? r_next : (r_next ^ 16'h0001);
    end

    function automatic logic [63:0] pk(input logic rdy, input logic eq, input logic nq,
                                       input logic ld, input logic fl,
                                       input logic [15:0] tg, input logic [15:0] cn);
        return {27'd0, rdy, eq, nq, ld, fl, tg, cn};
    endfunction

    assign obs  = pk(br_ready, cmp_eq, cmp_nq, pc_load, flush, pc_target, taken_count);
    assign obs0 = pk(rdy0, eq0, nq0, ld0, fl0, tg0, cnt0);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic put(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Expected per-cycle outputs for the cycles following the accept edge.
    task automatic push_exp(input logic [1:0] k, input logic [15:0] pc, input logic [15:0] off,
                            input logic r0, input string tag);
        logic        tk;
        logic [15:0] c0;
        c0 = exp_cnt;
        tk = (k == 2'b11) || (((k == 2'b01) || (k == 2'b10)) && r0);
        if (k == 2'b00) begin
            put(tag, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, c0));
        end else begin
            if (k != 2'b11) put(tag, pk(1'b0, k == 2'b01, k == 2'b10, 1'b0, 1'b0, 16'h0000, c0));
            if (tk) begin
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                put(tag, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pc + off, c0));
                for (int i = 0; i < FC; i++) put(tag, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, exp_cnt));
            end else begin
                put(tag, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, c0));
            end
            put(tag, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, exp_cnt));
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, obs, mon_e.v);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [15:0] pc, input logic [15:0] off,
                        input logic [15:0] r, input string tag);
        wait_idle();
        @(posedge clk);
        #1;
        br_valid  = 1'b1;
        br_kind   = k;
        br_pc     = pc;
        br_offset = off;
        r_next    = r;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        push_exp(k, pc, off, r[0], tag);
    endtask

    initial begin
        int nA;
        rst       = 1'b1;
        br_valid  = 1'b0;
        br_kind   = 2'b00;
        br_pc     = 16'h0000;
        br_offset = 16'h0000;
        r_next    = 16'h0000;
        exp_cnt   = 16'h0000;
        v0        = 1'b0;
        k0        = 2'b00;
        pc0       = 16'h0000;
        off0      = 16'h0000;

        #12;
        chk("reset_outputs", obs, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_ready", obs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));

        send(2'b01, 16'h0010, 16'h0004, 16'h0001, "beq_taken");
        send(2'b10, 16'h0020, 16'h0008, 16'hFFFE, "bne_not_taken");
        send(2'b11, 16'hFFFE, 16'h0005, 16'h0000, "jump_wrap");
        send(2'b11, 16'h0010, 16'hFFFC, 16'h0000, "jump_neg_off");
        send(2'b01, 16'h0100, 16'h0010, 16'hFFFE, "beq_not_taken");
        send(2'b10, 16'h0300, 16'h0030, 16'h8001, "bne_taken");
        send(2'b00, 16'h0400, 16'h0040, 16'h0001, "nop");
        for (int i = 0; i < 12; i++) begin
            send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom), "random");
        end

        // Second request held valid while the first is still in flight.
        wait_idle();
        @(posedge clk);
        #1;
        br_valid  = 1'b1;
        br_kind   = 2'b11;
        br_pc     = 16'h1000;
        br_offset = 16'h0234;
        @(posedge clk);
        #1;
        br_kind   = 2'b01;
        br_pc     = 16'h0040;
        br_offset = 16'hFFF0;
        r_next    = 16'h0001;
        push_exp(2'b11, 16'h1000, 16'h0234, 1'b0, "b2b_first");
        nA = sb.size();
        push_exp(2'b01, 16'h0040, 16'hFFF0, 1'b1, "b2b_second");
        repeat (nA) @(posedge clk);
        #1;
        br_valid = 1'b0;

        // Reset asserted in the middle of a flush.
        wait_idle();
        @(posedge clk);
        #1;
        br_valid  = 1'b1;
        br_kind   = 2'b11;
        br_pc     = 16'h0200;
        br_offset = 16'h0010;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        chk("rst_pre_load", obs, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0210, exp_cnt));
        @(posedge clk);
        #2;
        chk("rst_pre_flush", obs, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, exp_cnt + 16'd1));
        rst = 1'b1;
        #1;
        exp_cnt = 16'h0000;
        chk("rst_async_clear", obs, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));
        @(posedge clk);
        #1;
        chk("rst_held", obs, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release", obs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));
        @(posedge clk);
        #1;
        chk("rst_no_pending", obs, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));

        send(2'b01, 16'h0010, 16'h0004, 16'h0001, "beq_after_rst");
        wait_idle();

        // Build without a flush phase: jump returns to IDLE right after RESOLVE.
        @(posedge clk);
        #1;
        v0   = 1'b1;
        k0   = 2'b11;
        pc0  = 16'h0100;
        off0 = 16'h0020;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        @(negedge clk);
        chk("nof_load", obs0, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0120, 16'h0000));
        @(negedge clk);
        chk("nof_idle", obs0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
